// File: rtl/vx_fpu_rsp_arb_pkg.sv
// Shared FPU definitions used by the response arbiter and its clients.
//   FFLAGS_BITS : number of IEEE exception flag bits
//   fflags_t    : packed exception flags {NV, DZ, OF, UF, NX}, NV in the MSB
package vx_fpu_rsp_arb_pkg;

  localparam int unsigned FFLAGS_BITS = 5;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin request selector.
//   clk, reset   : clock, asynchronous active-high reset (pointer returns to 0)
//   requests     : one bit per requester
//   unlock       : advance the priority pointer past the current grant
//   grant_onehot : one-hot grant (zero when nothing requests)
//   grant_index  : binary index of the granted requester
//   grant_valid  : at least one requester is granted
module vx_rr_arbiter #(
  parameter int unsigned NUM_REQS = 5,
  localparam int unsigned IdxW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                unlock,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic [IdxW-1:0]     grant_index,
  output logic                grant_valid
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  int unsigned     idx;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    idx          = 0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQS;
      if (!grant_valid && requests[IdxW'(idx)]) begin
        grant_valid = 1'b1;
        grant_index = IdxW'(idx);
      end
    end
    grant_onehot[grant_index] = grant_valid;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (unlock && grant_valid) begin
      ptr_d = (grant_index == IdxW'(NUM_REQS - 1)) ? '0 : grant_index + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vx_fpu_rsp_arb.sv
// Merges responses of several FPU units into one stream through a round-robin
// selector and a 2-entry output FIFO.
//   clk, reset            : clock, asynchronous active-high reset
//   valid_in / ready_in   : per-unit response handshake (ready only for the granted unit)
//   tag_in, tmask_in,
//   result_in             : per-unit response payload, passed through unchanged
//   has_fflags_in,
//   fflags_in             : per-unit/per-lane exception flags
//   valid_out / ready_out : merged response handshake
//   tag_out, tmask_out, result_out, has_fflags_out, fflags_out : FIFO head payload;
//   fflags_out is the OR of flags over active lanes, zero when the unit reports none
module vx_fpu_rsp_arb
  import vx_fpu_rsp_arb_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 5,
  parameter int unsigned LANES     = 1,
  parameter int unsigned TAGW      = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic    [NUM_UNITS-1:0]             valid_in,
  output logic    [NUM_UNITS-1:0]             ready_in,
  input  logic    [NUM_UNITS-1:0][TAGW-1:0]   tag_in,
  input  logic    [NUM_UNITS-1:0][LANES-1:0]  tmask_in,
  input  logic    [NUM_UNITS-1:0][LANES-1:0][31:0] result_in,
  input  logic    [NUM_UNITS-1:0]             has_fflags_in,
  input  fflags_t [NUM_UNITS-1:0][LANES-1:0]  fflags_in,
  output logic                                valid_out,
  input  logic                                ready_out,
  output logic    [TAGW-1:0]                  tag_out,
  output logic    [LANES-1:0]                 tmask_out,
  output logic    [LANES-1:0][31:0]           result_out,
  output logic                                has_fflags_out,
  output fflags_t                             fflags_out
);

  localparam int unsigned IdxW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef struct packed {
    logic [TAGW-1:0]        tag;
    logic [LANES-1:0]       tmask;
    logic [LANES-1:0][31:0] result;
    logic                   has_fflags;
    fflags_t                fflags;
  } entry_t;

  logic [NUM_UNITS-1:0] grant_onehot;
  logic [IdxW-1:0]      grant_index;
  logic                 grant_valid;

  logic [1:0] count_q, count_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  entry_t     mem_q [2];
  entry_t     mem_d [2];
  entry_t     push_entry;
  logic [FFLAGS_BITS-1:0] ff_acc;

  logic can_push, push, pop;

  // Space is judged from the registered count only, so ready_out never
  // reaches ready_in combinationally.
  assign can_push = (count_q != 2'd2) && !reset;
  assign push     = grant_valid && can_push;
  assign pop      = valid_out && ready_out;
  assign ready_in = grant_onehot & {NUM_UNITS{can_push}};

  vx_rr_arbiter #(
    .NUM_REQS (NUM_UNITS)
  ) u_rr_arbiter (
    .clk          (clk),
    .reset        (reset),
    .requests     (valid_in),
    .unlock       (push),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index),
    .grant_valid  (grant_valid)
  );

  always_comb begin
    ff_acc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (has_fflags_in[grant_index] && tmask_in[grant_index][i]) begin
        ff_acc = ff_acc | fflags_in[grant_index][i];
      end
    end
    push_entry.tag        = tag_in[grant_index];
    push_entry.tmask      = tmask_in[grant_index];
    push_entry.result     = result_in[grant_index];
    push_entry.has_fflags = has_fflags_in[grant_index];
    push_entry.fflags     = fflags_t'(ff_acc);
  end

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q ^ pop;
    wr_d    = wr_q ^ push;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = push_entry;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Payload storage carries no reset; count gates its visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid_out      = (count_q != 2'd0);
  assign tag_out        = mem_q[rd_q].tag;
  assign tmask_out      = mem_q[rd_q].tmask;
  assign result_out     = mem_q[rd_q].result;
  assign has_fflags_out = mem_q[rd_q].has_fflags;
  assign fflags_out     = mem_q[rd_q].fflags;

endmodule

// File: tb/tb_vx_fpu_rsp_arb.sv
// Self-checking bench for vx_fpu_rsp_arb (5 units, 4 lanes, 8-bit tags).
module tb_vx_fpu_rsp_arb;
  import vx_fpu_rsp_arb_pkg::*;

  localparam int NU = 5;
  localparam int LN = 4;
  localparam int TW = 8;

  logic                         clk = 1'b0;
  logic                         reset;
  logic    [NU-1:0]             valid_in;
  logic    [NU-1:0]             ready_in;
  logic    [NU-1:0][TW-1:0]     tag_in;
  logic    [NU-1:0][LN-1:0]     tmask_in;
  logic    [NU-1:0][LN-1:0][31:0] result_in;
  logic    [NU-1:0]             has_fflags_in;
  fflags_t [NU-1:0][LN-1:0]     fflags_in;
  logic                         valid_out;
  logic                         ready_out;
  logic    [TW-1:0]             tag_out;
  logic    [LN-1:0]             tmask_out;
  logic    [LN-1:0][31:0]       result_out;
  logic                         has_fflags_out;
  fflags_t                      fflags_out;

  vx_fpu_rsp_arb #(
    .NUM_UNITS (NU),
    .LANES     (LN),
    .TAGW      (TW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .ready_in       (ready_in),
    .tag_in         (tag_in),
    .tmask_in       (tmask_in),
    .result_in      (result_in),
    .has_fflags_in  (has_fflags_in),
    .fflags_in      (fflags_in),
    .valid_out      (valid_out),
    .ready_out      (ready_out),
    .tag_out        (tag_out),
    .tmask_out      (tmask_out),
    .result_out     (result_out),
    .has_fflags_out (has_fflags_out),
    .fflags_out     (fflags_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0]      tag;
    logic [LN-1:0]      tmask;
    logic [LN*32-1:0]   result;
    logic               has;
    logic [4:0]         ff;
  } ent_t;

  int checks = 0;
  int failures = 0;

  // Reference model: priority pointer and buffered responses in order.
  int          ptr_m;
  ent_t        q_m[$];
  logic [NU-1:0] exp_ready;
  int          exp_g;
  logic        exp_valid;
  logic [TW-1:0] tag_ctr = 8'd1;

  function automatic logic [4:0] merge_ff(int u);
    logic [4:0] acc = 5'd0;
    if (has_fflags_in[u]) begin
      for (int i = 0; i < LN; i++) begin
        if (tmask_in[u][i]) acc = acc | fflags_in[u][i];
      end
    end
    return acc;
  endfunction

  task automatic new_resp(int u);
    tag_in[u]        = tag_ctr;
    tag_ctr          = tag_ctr + 8'd1;
    tmask_in[u]      = LN'($urandom);
    has_fflags_in[u] = 1'($urandom);
    for (int i = 0; i < LN; i++) begin
      result_in[u][i] = $urandom;
      fflags_in[u][i] = fflags_t'(5'($urandom));
    end
  endtask

  // Expected handshake for the current cycle, from model state and driven inputs.
  task automatic predict();
    exp_g = -1;
    for (int k = 0; k < NU; k++) begin
      int u = (ptr_m + k) % NU;
      if (valid_in[u] && exp_g < 0) exp_g = u;
    end
    exp_ready = '0;
    if (exp_g >= 0 && q_m.size() < 2) exp_ready[exp_g] = 1'b1;
    exp_valid = (q_m.size() > 0);
  endtask

  // Cross the active edge and update the model; returns the accepted unit or -1.
  task automatic advance(output int fired);
    ent_t e;
    bit   push;
    push = (exp_ready != '0);
    if (push) begin
      e.tag    = tag_in[exp_g];
      e.tmask  = tmask_in[exp_g];
      e.result = result_in[exp_g];
      e.has    = has_fflags_in[exp_g];
      e.ff     = merge_ff(exp_g);
    end
    @(posedge clk);
    if (exp_valid && ready_out && q_m.size() > 0) q_m.delete(0);
    if (push) begin
      q_m.push_back(e);
      ptr_m = (exp_g + 1) % NU;
    end
    fired = push ? exp_g : -1;
    #1;
  endtask

  task automatic drain();
    int f;
    valid_in  = '0;
    ready_out = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      predict();
      checks++;
      if (valid_out !== exp_valid) begin
        failures++;
        $display("FAIL drain_valid got=%b want=%b", valid_out, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (tag_out !== q_m[0].tag || result_out !== q_m[0].result ||
            5'(fflags_out) !== q_m[0].ff || tmask_out !== q_m[0].tmask ||
            has_fflags_out !== q_m[0].has) begin
          failures++;
          $display("FAIL drain_head tag got=%h want=%h ff got=%b want=%b",
                   tag_out, q_m[0].tag, 5'(fflags_out), q_m[0].ff);
        end
      end
      advance(f);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    valid_in  = '1;
    ready_out = 1'b1;
    for (int u = 0; u < NU; u++) new_resp(u);
    #3;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (valid_out !== 1'b0 || ready_in !== '0) begin
        failures++;
        $display("FAIL reset_state valid_out=%b ready_in=%b want 0/00000", valid_out, ready_in);
      end
      @(negedge clk);
    end
    valid_in = '0;
    reset    = 1'b0;
    ptr_m    = 0;
    q_m.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_rr_024();
    int f;
    logic [NU-1:0] want;
    valid_in  = 5'b10101;
    ready_out = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      predict();
      want = NU'(1) << ((k % 3) * 2);
      checks++;
      if (ready_in !== want || ready_in !== exp_ready) begin
        failures++;
        $display("FAIL rr_grant cycle=%0d got=%b want=%b", k, ready_in, want);
      end
      checks++;
      if (valid_out !== (k >= 1)) begin
        failures++;
        $display("FAIL rr_valid cycle=%0d got=%b want=%b", k, valid_out, (k >= 1));
      end
      if (k >= 1) begin
        checks++;
        if (tag_out !== q_m[0].tag || result_out !== q_m[0].result) begin
          failures++;
          $display("FAIL rr_head cycle=%0d tag got=%h want=%h", k, tag_out, q_m[0].tag);
        end
      end
      advance(f);
      if (f >= 0) new_resp(f);
    end
    drain();
  endtask

  task automatic test_fflags();
    int f;
    for (int pass = 0; pass < 2; pass++) begin
      valid_in         = 5'b00010;
      ready_out        = 1'b1;
      tmask_in[1]      = 4'b0101;
      has_fflags_in[1] = (pass == 0);
      fflags_in[1][0]  = fflags_t'(5'b10000);
      fflags_in[1][1]  = fflags_t'(5'b00000);
      fflags_in[1][2]  = fflags_t'(5'b00001);
      fflags_in[1][3]  = fflags_t'(5'b00100);
      for (int i = 0; i < LN; i++) result_in[1][i] = $urandom;
      @(negedge clk);
      predict();
      checks++;
      if (ready_in !== 5'b00010) begin
        failures++;
        $display("FAIL ff_ready pass=%0d got=%b want=00010", pass, ready_in);
      end
      advance(f);
      valid_in = '0;
      @(negedge clk);
      predict();
      checks++;
      if (valid_out !== 1'b1 || 5'(fflags_out) !== ((pass == 0) ? 5'b10001 : 5'b00000)) begin
        failures++;
        $display("FAIL ff_value pass=%0d valid=%b got=%b want=%b", pass, valid_out,
                 5'(fflags_out), (pass == 0) ? 5'b10001 : 5'b00000);
      end
      checks++;
      if (result_out !== result_in[1] || tmask_out !== 4'b0101 ||
          has_fflags_out !== (pass == 0)) begin
        failures++;
        $display("FAIL ff_passthru pass=%0d result got=%h want=%h", pass, result_out,
                 result_in[1]);
      end
      advance(f);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int f;
    int acc = 0;
    logic [TW-1:0] sent[$];
    ready_out   = 1'b0;
    valid_in    = 5'b01000;
    new_resp(3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      predict();
      if (ready_in[3] === 1'b1) acc++;
      checks++;
      if (ready_in !== exp_ready || (k >= 2 && ready_in[3] !== 1'b0)) begin
        failures++;
        $display("FAIL bp_ready cycle=%0d got=%b want=%b", k, ready_in, exp_ready);
      end
      if (k >= 1) begin
        checks++;
        if (valid_out !== 1'b1 || tag_out !== sent[0]) begin
          failures++;
          $display("FAIL bp_stable cycle=%0d valid=%b tag got=%h want=%h", k, valid_out,
                   tag_out, sent[0]);
        end
      end
      advance(f);
      if (f == 3) begin
        sent.push_back(tag_in[3]);
        new_resp(3);
      end
    end
    checks++;
    if (acc != 2) begin
      failures++;
      $display("FAIL bp_accepted got=%0d want=2", acc);
    end
    valid_in  = '0;
    ready_out = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      predict();
      checks++;
      if (valid_out !== 1'b1 || sent.size() == 0 || tag_out !== sent[0]) begin
        failures++;
        $display("FAIL bp_drain idx=%0d valid=%b tag got=%h", k, valid_out, tag_out);
      end
      if (sent.size() > 0) sent.delete(0);
      advance(f);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int f;
    ready_out = 1'b0;
    valid_in  = 5'b00001;
    new_resp(0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      predict();
      advance(f);
      if (f == 0) new_resp(0);
    end
    checks++;
    if (valid_out !== 1'b1) begin
      failures++;
      $display("FAIL rmid_prefill valid got=%b want=1", valid_out);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || ready_in !== '0) begin
      failures++;
      $display("FAIL rmid_async valid=%b ready_in=%b want 0/00000", valid_out, ready_in);
    end
    q_m.delete();
    ptr_m = 0;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    ready_out = 1'b1;
    valid_in  = 5'b10010;
    new_resp(1);
    new_resp(4);
    #1;
    predict();
    checks++;
    if (ready_in !== 5'b00010) begin
      failures++;
      $display("FAIL rmid_first got=%b want=00010", ready_in);
    end
    advance(f);
    if (f >= 0) valid_in[f] = 1'b0;
    @(negedge clk);
    predict();
    checks++;
    if (ready_in !== 5'b10000 || valid_out !== 1'b1 || tag_out !== q_m[0].tag) begin
      failures++;
      $display("FAIL rmid_second ready_in=%b want=10000 valid=%b", ready_in, valid_out);
    end
    advance(f);
    drain();
  endtask

  task automatic test_random();
    int f;
    int n_sent = 0;
    int n_recv = 0;
    logic [TW-1:0]    sb_tag[$];
    logic [LN*32-1:0] sb_res[$];
    valid_in = '0;
    for (int c = 0; c < 1000; c++) begin
      if (!valid_in[2] && ($urandom % 2 == 0)) begin
        new_resp(2);
        valid_in[2] = 1'b1;
      end
      ready_out = 1'($urandom);
      @(negedge clk);
      predict();
      checks++;
      if (ready_in !== exp_ready || valid_out !== exp_valid) begin
        failures++;
        $display("FAIL rnd_hs cycle=%0d ready_in=%b want=%b valid=%b want=%b", c, ready_in,
                 exp_ready, valid_out, exp_valid);
      end
      if (valid_out && ready_out) begin
        checks++;
        if (sb_tag.size() == 0 || tag_out !== sb_tag[0] || result_out !== sb_res[0]) begin
          failures++;
          $display("FAIL rnd_order cycle=%0d tag got=%h", c, tag_out);
        end
        if (sb_tag.size() > 0) begin
          sb_tag.delete(0);
          sb_res.delete(0);
        end
        n_recv++;
      end
      advance(f);
      if (f == 2) begin
        sb_tag.push_back(tag_in[2]);
        sb_res.push_back(result_in[2]);
        n_sent++;
        valid_in[2] = 1'b0;
      end
    end
    valid_in  = '0;
    ready_out = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (valid_out) begin
        checks++;
        if (sb_tag.size() == 0 || tag_out !== sb_tag[0]) begin
          failures++;
          $display("FAIL rnd_tail tag got=%h", tag_out);
        end
        if (sb_tag.size() > 0) begin
          sb_tag.delete(0);
          sb_res.delete(0);
        end
        n_recv++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (n_recv != n_sent || n_sent < 100) begin
      failures++;
      $display("FAIL rnd_count recv=%0d sent=%0d", n_recv, n_sent);
    end
  endtask

  initial begin
    valid_in      = '0;
    ready_out     = 1'b0;
    tag_in        = '0;
    tmask_in      = '0;
    result_in     = '0;
    has_fflags_in = '0;
    fflags_in     = '0;
    test_reset();
    test_rr_024();
    test_fflags();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_fpu_rsp_arb.md
VX_FPU_RSP_ARB -- requirements
Module: VX_fpu_rsp_arb

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 5, number of FP core units (ncomp, fma, div, sqrt, cvt) whose responses are merged.
REQ-002 SHALL have parameter LANES, default 1, SIMD lanes per response.
REQ-003 SHALL have parameter TAGW, default 1, tag width carried unchanged.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port valid_in, input, NUM_UNITS, per-unit response valid.
REQ-007 SHALL have port ready_in, output, NUM_UNITS, per-unit response accepted this cycle.
REQ-008 SHALL have port tag_in, input, NUM_UNITS x TAGW, per-unit tag.
REQ-009 SHALL have port tmask_in, input, NUM_UNITS x LANES, per-unit active-lane mask.
REQ-010 SHALL have port result_in, input, NUM_UNITS x LANES x 32, per-unit lane results.
REQ-011 SHALL have port has_fflags_in, input, NUM_UNITS, unit reports exception flags.
REQ-012 SHALL have port fflags_in, input, NUM_UNITS x LANES x fflags_t, per-lane flags {NV,DZ,OF,UF,NX}.
REQ-013 SHALL have port valid_out / ready_out, output / input, 1 each, merged response handshake.
REQ-014 SHALL have ports tag_out (TAGW), tmask_out (LANES), result_out (LANES x 32), has_fflags_out (1), fflags_out (fflags_t), all outputs.

Function
REQ-015 SHALL select one requesting unit per cycle by round-robin; priority pointer starts at unit 0 after reset.
REQ-016 SHALL advance pointer to (granted+1) mod NUM_UNITS only on an accepted transfer (valid_in[g] & ready_in[g]); unchanged otherwise.
REQ-017 SHALL assert ready_in[g] only for the granted unit g and only when the output buffer holds fewer than 2 entries; all other ready_in bits 0.
REQ-018 SHALL hold ready_in combinationally independent of ready_out (no combinational path ready_out -> ready_in).
REQ-019 SHALL store each accepted response in a 2-entry FIFO output buffer; valid_out = buffer non-empty; outputs driven from FIFO head registers.
REQ-020 SHALL have latency exactly 1 cycle from acceptance to valid_out when buffer empty; full throughput (1 response/cycle) with ready_out held high.
REQ-021 SHALL pop head on valid_out & ready_out; simultaneous push and pop at count 1 leaves count 1 with new entry at head next cycle; at count 2 no push occurs.
REQ-022 SHALL hold all outputs stable while valid_out & ~ready_out.
REQ-023 SHALL compute fflags_out at push time as bitwise OR of fflags_in[g][i] over lanes i with tmask_in[g][i]=1; fflags_out = 0 when has_fflags_in[g]=0.
REQ-024 SHALL pass tag, tmask, result, has_fflags unmodified.
REQ-025 SHALL treat valid_in bits with no grant as ignored (unit must hold its response; no data loss).

Reset
REQ-026 SHALL on reset clear FIFO count and pointers, set pointer to 0, drive valid_out=0, ready_in=0 while reset asserted; data registers need no reset.
REQ-027 SHALL discard buffered entries on reset asserted mid-operation; first response after deassertion taken by round-robin from unit 0.

Structure
REQ-028 SHALL take fflags_t and FFLAGS_BITS from the shared FPU define package; no new typedefs there.
REQ-029 SHALL implement the round-robin selector as sub-module VX_rr_arbiter (NUM_REQS parameter, requests in, one-hot grant and index out, unlock input for pointer advance).

Verification
REQ-030 SHALL check: units 0,2,4 valid every cycle, ready_out=1 -> grants 0,2,4,0,2,4..., valid_out every cycle from cycle 1.
REQ-031 SHALL check: LANES=4, unit 1 fflags lanes {NV,0,NX,OF}, tmask 4'b0101, has_fflags=1 -> fflags_out = NV|NX (5'b10001).
REQ-032 SHALL check: same response with has_fflags=0 -> fflags_out = 0, result_out equals result_in bitwise.
REQ-033 SHALL check: ready_out=0 for 5 cycles, unit 3 valid continuously -> exactly 2 accepted, ready_in[3]=0 afterwards, outputs stable; ready_out=1 -> both drained in order, tags preserved.
REQ-034 SHALL check: reset asserted with 2 entries buffered -> valid_out=0 immediately (asynchronous); after release, units 1 and 4 valid -> unit 1 granted first.
REQ-035 SHALL check: single unit 2 toggling valid with random ready_out over 1000 cycles -> output sequence matches input sequence, no drops or duplicates.
